mul_unit: RTL

Iterative multi-cycle multiply/accumulate unit for the execute stage. It takes the MUL, MLA and MLS operations off the single-cycle ALU's combinational path. Operands come from the register-file read ports, and the result is muxed with the ALU result into writeback. While the unit is busy, the core stalls on `busy`.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_ctrl.sv | 67 ++++++
 rtl/mul_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants and types for the iterative multiply/accumulate unit.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 32;

  localparam logic [1:0] MUL_OP_MUL = 2'b00;
  localparam logic [1:0] MUL_OP_MLA = 2'b01;
  localparam logic [1:0] MUL_OP_MLS = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    ACC  = 2'b10,
    DONE = 2'b11
  } mul_state_t;

endpackage

// File: rtl/mul_ctrl.sv
// Sequencer for mul_unit: IDLE/RUN/ACC/DONE state machine plus shift-add iteration counter.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic early_stop,
  output logic load,
  output logic step,
  output logic acc_en,
  output logic busy,
  output logic done
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t    state, state_next;
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (load)
        count <= '0;
      else if (step)
        count <= count + CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    acc_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        // Leave RUN after the last step, or as soon as no multiplier bits remain.
        if (count == LAST || early_stop)
          state_next = ACC;
      end
      ACC: begin
        acc_en     = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: rtl/mul_unit.sv
// Iterative radix-2 MUL/MLA/MLS unit; shift-add datapath and final accumulate.
// Optional `MUL_EARLY_TERM_EN: ends RUN once the remaining multiplier bits are zero.
module mul_unit
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] src_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags
);

  logic             load, step, acc_en, early_stop;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] ma, mb, c_q, acc, final_val;

`ifdef MUL_EARLY_TERM_EN
  assign early_stop = ~|mb[WIDTH-1:1];
`else
  assign early_stop = 1'b0;
`endif

  mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .early_stop (early_stop),
    .load       (load),
    .step       (step),
    .acc_en     (acc_en),
    .busy       (busy),
    .done       (done)
  );

  // Reserved op encoding behaves as a plain multiply.
  always_comb begin
    case (op_q)
      MUL_OP_MLA: final_val = c_q + acc;
      MUL_OP_MLS: final_val = c_q - acc;
      default:    final_val = acc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      ma     <= '0;
      mb     <= '0;
      c_q    <= '0;
      acc    <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (load) begin
        op_q <= op;
        ma   <= src_a;
        mb   <= src_b;
        c_q  <= src_c;
        acc  <= '0;
      end else if (step) begin
        if (mb[0])
          acc <= acc + ma;
        ma <= ma << 1;
        mb <= mb >> 1;
      end
      if (acc_en) begin
        result <= final_val;
        flags  <= {final_val[WIDTH-1], final_val == '0};
      end
    end
  end

endmodule
